mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates NPORTS cache-miss ports onto one unified memory port. Each grant is an
// optional line write-back followed by an optional line fill, with a completion pulse.
module mem_port_arbiter #(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64,
    parameter int RR     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          req_re,
    input  logic [NPORTS-1:0]          req_we,
    input  logic [NPORTS*ADDR_W-1:0]   req_raddr,
    input  logic [NPORTS*ADDR_W-1:0]   req_waddr,
    input  logic [NPORTS*LINE_W-1:0]   req_wdata,
    output logic [NPORTS-1:0]          req_rdy,
    output logic [LINE_W-1:0]          rd_data,
    output logic [NPORTS-1:0]          grant,
    output logic                       busy,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_rdy
);

    localparam int PW = $clog2(NPORTS);
    localparam logic [NPORTS-1:0] ONE_HOT0 = {{(NPORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       rr_ptr_q;
    logic [PW-1:0]       gnt_idx_q;
    logic                lat_re_q;
    logic [ADDR_W-1:0]   lat_raddr_q;
    logic [NPORTS-1:0]   grant_q;
    logic [NPORTS-1:0]   req_rdy_q;
    logic                busy_q;
    logic                mem_re_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;
    logic [LINE_W-1:0]   rd_data_q;

    logic [NPORTS-1:0]   req_any_d;
    logic [PW-1:0]       sel_idx_d;
    logic                sel_vld_d;
    int                  cand_idx_d;

    assign req_any_d = req_re | req_we;

    // Candidate search: rotates from the port after the last grant, or from port 0 in fixed mode.
    always_comb begin
        sel_idx_d  = '0;
        sel_vld_d  = 1'b0;
        cand_idx_d = 0;
        for (int i = 0; i < NPORTS; i++) begin
            cand_idx_d = (RR != 0) ? ((int'(rr_ptr_q) + 1 + i) % NPORTS) : i;
            sel_idx_d  = (!sel_vld_d && req_any_d[cand_idx_d[PW-1:0]]) ? cand_idx_d[PW-1:0] : sel_idx_d;
            sel_vld_d  = sel_vld_d | req_any_d[cand_idx_d[PW-1:0]];
        end
    end

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PW'(NPORTS - 1);
            gnt_idx_q   <= '0;
            lat_re_q    <= 1'b0;
            lat_raddr_q <= '0;
            grant_q     <= '0;
            req_rdy_q   <= '0;
            busy_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld_d) begin
                        gnt_idx_q   <= sel_idx_d;
                        grant_q     <= ONE_HOT0 << sel_idx_d;
                        busy_q      <= 1'b1;
                        lat_re_q    <= req_re[sel_idx_d];
                        lat_raddr_q <= req_raddr[sel_idx_d*ADDR_W +: ADDR_W];
                        if (req_we[sel_idx_d]) begin
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_waddr[sel_idx_d*ADDR_W +: ADDR_W];
                            mem_wdata_q <= req_wdata[sel_idx_d*LINE_W +: LINE_W];
                        end else begin
                            state_q    <= READ;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= req_raddr[sel_idx_d*ADDR_W +: ADDR_W];
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_rdy) begin
                        mem_we_q <= 1'b0;
                        // Evict-then-fill keeps the grant and moves straight to the fill.
                        if (lat_re_q) begin
                            state_q    <= READ;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= lat_raddr_q;
                        end else begin
                            state_q   <= DONE;
                            req_rdy_q <= grant_q;
                        end
                    end else begin
                        state_q <= WRITE;
                    end
                end
                READ: begin
                    if (mem_rdy) begin
                        mem_re_q  <= 1'b0;
                        rd_data_q <= mem_rdata;
                        state_q   <= DONE;
                        req_rdy_q <= grant_q;
                    end else begin
                        state_q <= READ;
                    end
                end
                DONE: begin
                    req_rdy_q <= '0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    rr_ptr_q  <= gnt_idx_q;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= '0;
                    req_rdy_q <= '0;
                    busy_q    <= 1'b0;
                    mem_re_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_rdy   = req_rdy_q;
    assign rd_data   = rd_data_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on two-port round-robin and fixed-priority
// instances, plus randomized traffic on a four-port instance against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int LW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]      re2, we2;
    logic [2*AW-1:0] raddr2, waddr2;
    logic [2*LW-1:0] wdata2;

    logic [1:0]    a_rdy, a_grant;
    logic [LW-1:0] a_rd_data, a_mem_wdata, a_mem_rdata;
    logic          a_busy, a_mem_re, a_mem_we, a_mem_rdy;
    logic [AW-1:0] a_mem_addr;

    logic [1:0]    b_rdy, b_grant;
    logic [LW-1:0] b_rd_data, b_mem_wdata, b_mem_rdata;
    logic          b_busy, b_mem_re, b_mem_we, b_mem_rdy;
    logic [AW-1:0] b_mem_addr;

    logic [3:0]      c_re, c_we, c_rdy, c_grant;
    logic [4*AW-1:0] c_raddr, c_waddr;
    logic [4*LW-1:0] c_wdata;
    logic [LW-1:0]   c_rd_data, c_mem_wdata, c_mem_rdata;
    logic            c_busy, c_mem_re, c_mem_we, c_mem_rdy;
    logic [AW-1:0]   c_mem_addr;

    assign b_mem_rdy   = b_mem_re | b_mem_we;
    assign b_mem_rdata = '0;

    mem_port_arbiter #(.NPORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR(1)) u_a (
        .clk(clk), .rst(rst), .req_re(re2), .req_we(we2), .req_raddr(raddr2),
        .req_waddr(waddr2), .req_wdata(wdata2), .req_rdy(a_rdy), .rd_data(a_rd_data),
        .grant(a_grant), .busy(a_busy), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_rdy(a_mem_rdy));

    mem_port_arbiter #(.NPORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR(0)) u_b (
        .clk(clk), .rst(rst), .req_re(re2), .req_we(we2), .req_raddr(raddr2),
        .req_waddr(waddr2), .req_wdata(wdata2), .req_rdy(b_rdy), .rd_data(b_rd_data),
        .grant(b_grant), .busy(b_busy), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_rdy(b_mem_rdy));

    mem_port_arbiter #(.NPORTS(4), .ADDR_W(AW), .LINE_W(LW), .RR(1)) u_c (
        .clk(clk), .rst(rst), .req_re(c_re), .req_we(c_we), .req_raddr(c_raddr),
        .req_waddr(c_waddr), .req_wdata(c_wdata), .req_rdy(c_rdy), .rd_data(c_rd_data),
        .grant(c_grant), .busy(c_busy), .mem_re(c_mem_re), .mem_we(c_mem_we),
        .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .mem_rdy(c_mem_rdy));

    // Four-port requester state and memory contents seen by the model.
    logic [3:0]    pend_re = 4'b0000;
    logic [3:0]    pend_we = 4'b0000;
    logic [AW-1:0] p_raddr [4];
    logic [AW-1:0] p_waddr [4];
    logic [LW-1:0] p_wdata [4];
    logic [LW-1:0] mem_m [logic [AW-1:0]];
    int            last_c = 3;
    logic [LW-1:0] exp_rd = '0;

    logic [1:0] ga [4];
    logic [1:0] gb [4];
    int         na, nb;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c();
        c_re = pend_re;
        c_we = pend_we;
        for (int p = 0; p < 4; p++) begin
            c_raddr[p*AW +: AW] = p_raddr[p];
            c_waddr[p*AW +: AW] = p_waddr[p];
            c_wdata[p*LW +: LW] = p_wdata[p];
        end
    endtask

    // One complete four-port transaction; fresh=1 lets idle ports raise new random requests.
    task automatic c_txn(input bit fresh);
        int gp;
        int kind;
        int lat;
        logic [3:0]    oh;
        logic [LW-1:0] rv;
        if (fresh) begin
            for (int p = 0; p < 4; p++) begin
                if (pend_re[p] == 1'b0 && pend_we[p] == 1'b0 && $urandom_range(1, 0) == 1) begin
                    kind       = $urandom_range(2, 0);
                    pend_re[p] = (kind != 1);
                    pend_we[p] = (kind != 0);
                    p_raddr[p] = 14'($urandom_range(7, 0));
                    p_waddr[p] = 14'($urandom_range(7, 0));
                    p_wdata[p] = {$urandom, $urandom};
                end
            end
            if ((pend_re | pend_we) == 4'b0000) begin
                gp          = $urandom_range(3, 0);
                pend_re[gp] = 1'b1;
                p_raddr[gp] = 14'($urandom_range(7, 0));
            end
        end
        drive_c();
        gp = -1;
        for (int k = 1; k <= 4; k++) begin
            if (gp < 0 && (pend_re[(last_c + k) % 4] | pend_we[(last_c + k) % 4])) gp = (last_c + k) % 4;
        end
        oh = 4'b0001 << gp;
        tick();
        check_val("c_grant", c_grant, oh);
        check_val("c_busy", c_busy, 1'b1);
        if (pend_we[gp]) begin
            check_val("c_we", c_mem_we, 1'b1);
            check_val("c_we_excl", c_mem_re, 1'b0);
            check_val("c_waddr", c_mem_addr, p_waddr[gp]);
            check_val("c_wdata", c_mem_wdata, p_wdata[gp]);
            lat = $urandom_range(2, 0);
            c_mem_rdy = 1'b0;
            repeat (lat) begin
                tick();
                check_val("c_we_hold", {c_mem_we, c_mem_re}, 2'b10);
            end
            c_mem_rdy = 1'b1;
            tick();
            c_mem_rdy = 1'b0;
            mem_m[p_waddr[gp]] = p_wdata[gp];
        end
        if (pend_re[gp]) begin
            check_val("c_re", {c_mem_re, c_mem_we}, 2'b10);
            check_val("c_raddr", c_mem_addr, p_raddr[gp]);
            check_val("c_grant_fill", c_grant, oh);
            rv = mem_m.exists(p_raddr[gp]) ? mem_m[p_raddr[gp]] : {$urandom, $urandom};
            c_mem_rdata = rv;
            lat = $urandom_range(2, 0);
            repeat (lat) begin
                tick();
                check_val("c_re_hold", {c_mem_re, c_mem_we}, 2'b10);
            end
            c_mem_rdy = 1'b1;
            tick();
            c_mem_rdy = 1'b0;
            exp_rd = rv;
        end
        check_val("c_req_rdy", c_rdy, oh);
        check_val("c_rd_data", c_rd_data, exp_rd);
        check_val("c_done_strobes", {c_mem_re, c_mem_we}, 2'b00);
        pend_re[gp] = 1'b0;
        pend_we[gp] = 1'b0;
        drive_c();
        last_c = gp;
        tick();
        check_val("c_idle_grant", c_grant, 4'b0000);
        check_val("c_idle_rdy", c_rdy, 4'b0000);
        check_val("c_idle_busy", c_busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        re2 = '0; we2 = '0; raddr2 = '0; waddr2 = '0; wdata2 = '0;
        a_mem_rdata = '0; a_mem_rdy = 1'b0;
        c_mem_rdata = '0; c_mem_rdy = 1'b0;
        for (int p = 0; p < 4; p++) begin
            p_raddr[p] = '0; p_waddr[p] = '0; p_wdata[p] = '0;
        end
        drive_c();
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_grant", a_grant, 2'b00);
        check_val("rst_rdy", a_rdy, 2'b00);
        check_val("rst_busy", a_busy, 1'b0);
        check_val("rst_strobes", {a_mem_re, a_mem_we}, 2'b00);
        check_val("rst_addr", a_mem_addr, 14'h0000);
        check_val("rst_wdata", a_mem_wdata, 64'h0);
        check_val("rst_rd_data", a_rd_data, 64'h0);
        check_val("rst_b", {b_grant, b_rdy, b_busy, b_mem_addr}, 19'h0);
        check_val("rst_b_data", b_rd_data | b_mem_wdata, 64'h0);
        check_val("rst_c", {c_grant, c_rdy, c_busy, c_mem_re, c_mem_we}, 11'h0);

        // Port 1 fill with a three-cycle memory response.
        re2 = 2'b10;
        raddr2 = {14'h0123, 14'h0000};
        a_mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check_val("f1_strobes", {a_mem_re, a_mem_we}, 2'b10);
        check_val("f1_addr", a_mem_addr, 14'h0123);
        check_val("f1_grant", a_grant, 2'b10);
        check_val("f1_busy", a_busy, 1'b1);
        check_val("f1_rdy_early", a_rdy, 2'b00);
        tick();
        tick();
        check_val("f1_hold", a_mem_re, 1'b1);
        a_mem_rdy = 1'b1;
        tick();
        a_mem_rdy = 1'b0;
        check_val("f1_req_rdy", a_rdy, 2'b10);
        check_val("f1_rd_data", a_rd_data, 64'hDEAD_BEEF_CAFE_F00D);
        check_val("f1_re_drop", a_mem_re, 1'b0);
        re2 = 2'b00;
        tick();
        check_val("f1_rdy_once", a_rdy, 2'b00);
        check_val("f1_idle", {a_grant, a_busy}, 3'b000);

        // Port 0 evict-then-fill while port 1 waits.
        re2 = 2'b11; we2 = 2'b01;
        raddr2 = {14'h0200, 14'h0080};
        waddr2 = {14'h0000, 14'h0040};
        wdata2 = {64'h0, 64'h1111_2222_3333_4444};
        a_mem_rdy = 1'b1;
        a_mem_rdata = 64'h0BAD_F00D_0000_0080;
        tick();
        check_val("eb_wr_strobes", {a_mem_re, a_mem_we}, 2'b01);
        check_val("eb_waddr", a_mem_addr, 14'h0040);
        check_val("eb_wdata", a_mem_wdata, 64'h1111_2222_3333_4444);
        check_val("eb_wr_grant", a_grant, 2'b01);
        tick();
        check_val("eb_rd_strobes", {a_mem_re, a_mem_we}, 2'b10);
        check_val("eb_raddr", a_mem_addr, 14'h0080);
        check_val("eb_rd_grant", a_grant, 2'b01);
        check_val("eb_rdy_early", a_rdy, 2'b00);
        tick();
        check_val("eb_req_rdy", a_rdy, 2'b01);
        check_val("eb_rd_data", a_rd_data, 64'h0BAD_F00D_0000_0080);
        re2 = 2'b10; we2 = 2'b00;
        tick();
        check_val("eb_idle", {a_grant, a_rdy}, 4'b0000);
        a_mem_rdata = 64'h7777_0000_0000_0200;
        tick();
        check_val("eb_p1_grant", a_grant, 2'b10);
        check_val("eb_p1_addr", a_mem_addr, 14'h0200);
        tick();
        check_val("eb_p1_rdy", a_rdy, 2'b10);
        check_val("eb_p1_data", a_rd_data, 64'h7777_0000_0000_0200);
        re2 = 2'b00;
        tick();

        // Write-only transaction must leave rd_data alone.
        we2 = 2'b10;
        waddr2 = {14'h0333, 14'h0000};
        wdata2 = {64'hABCD_0123_4567_89EF, 64'h0};
        a_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check_val("wo_strobes", {a_mem_re, a_mem_we}, 2'b01);
        check_val("wo_addr", a_mem_addr, 14'h0333);
        check_val("wo_wdata", a_mem_wdata, 64'hABCD_0123_4567_89EF);
        tick();
        check_val("wo_rdy", a_rdy, 2'b10);
        check_val("wo_rd_data", a_rd_data, 64'h7777_0000_0000_0200);
        we2 = 2'b00;
        tick();

        // Reset in the middle of a fill, then minimum-latency fill.
        re2 = 2'b10;
        raddr2 = {14'h0055, 14'h0000};
        a_mem_rdy = 1'b0;
        tick();
        check_val("ra_in_read", a_mem_re, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("ra_grant", a_grant, 2'b00);
        check_val("ra_rdy", a_rdy, 2'b00);
        check_val("ra_busy", a_busy, 1'b0);
        check_val("ra_strobes", {a_mem_re, a_mem_we}, 2'b00);
        check_val("ra_addr", a_mem_addr, 14'h0000);
        check_val("ra_rd_data", a_rd_data, 64'h0);
        re2 = 2'b11;
        raddr2 = {14'h0066, 14'h0044};
        a_mem_rdy = 1'b1;
        a_mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        check_val("ra_p0_grant", a_grant, 2'b01);
        check_val("lat_cycle1", {a_mem_re, a_mem_addr}, {1'b1, 14'h0044});
        tick();
        check_val("lat_cycle2", a_rdy, 2'b01);
        check_val("lat_data", a_rd_data, 64'h0123_4567_89AB_CDEF);
        re2 = 2'b00;
        tick();
        check_val("lat_rdy_off", a_rdy, 2'b00);

        // Both ports requesting continuously: alternation vs. fixed priority.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re2 = 2'b11; we2 = 2'b00;
        na = 0; nb = 0;
        for (int k = 0; k < 4; k++) begin
            ga[k] = 2'b00;
            gb[k] = 2'b00;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (a_rdy != 2'b00 && na < 4) begin
                ga[na] = a_rdy;
                na++;
            end
            if (b_rdy != 2'b00 && nb < 4) begin
                gb[nb] = b_rdy;
                nb++;
            end
        end
        re2 = 2'b00;
        check_val("rr_count", 64'(na), 64'd4);
        check_val("fp_count", 64'(nb), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check_val("rr_order", ga[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            check_val("fp_order", gb[k], 2'b01);
        end

        // Four ports: port 3 served, then ports 1 and 3 contend and the pointer wraps to 1.
        pend_re = 4'b1000;
        p_raddr[3] = 14'h0003;
        c_txn(1'b0);
        pend_re = 4'b1010;
        p_raddr[1] = 14'h0001;
        c_txn(1'b0);
        check_val("wrap_last", 64'(last_c), 64'd1);

        repeat (150) c_txn(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
